// File: rtl/sigmoid_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : sigmoid_rr_scheduler (with FixedPoint package)
//  Description : Round-robin sharing of one sigmoid approximation across
//                N_REQ requesters through a two-stage valid/ready pipeline.
//  Revision    : 1.0  initial release
// ============================================================================

package FixedPoint;
    localparam int SFP_W    = 16;
    localparam int SFP_FRAC = 8;

    // Signed Q7.8 operand/result format
    typedef logic signed [SFP_W-1:0] sfp;

    localparam sfp SFP_ONE   = sfp'(1 << SFP_FRAC);
    localparam sfp SFP_HALF  = sfp'(1 << (SFP_FRAC - 1));
    localparam sfp SFP_FIVE  = sfp'(5 << SFP_FRAC);
    localparam sfp SFP_NFIVE = sfp'(-(5 << SFP_FRAC));
endpackage

module sigmoid_rr_scheduler #(
    parameter  int N_REQ = 4,
    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  FixedPoint::sfp [N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        rsp_valid,
    output FixedPoint::sfp              rsp_data,
    output logic [IDW-1:0]              rsp_id,
    input  logic                        rsp_ready,
    output logic                        busy
);
    import FixedPoint::*;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic           s1_valid_q,   s1_valid_d;
    sfp             s1_x_q,       s1_x_d;
    logic [IDW-1:0] s1_id_q,      s1_id_d;
    logic           rsp_valid_q,  rsp_valid_d;
    sfp             rsp_data_q,   rsp_data_d;
    logic [IDW-1:0] rsp_id_q,     rsp_id_d;
    logic           ready_en_q,   ready_en_d;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [N_REQ-1:0]  grant;
    logic [IDW-1:0]    grant_idx;
    logic              grant_any;
    logic [IDW-1:0]    cand_idx;
    logic              s1_load;
    logic              s2_load;
    logic              accept;
    logic signed [SFP_W:0] lin;
    sfp                sig_y;

    // Round-robin search starting just after the last accepted requester
    always_comb begin
        grant     = '0;
        grant_idx = last_grant_q;
        grant_any = 1'b0;
        cand_idx  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_idx = IDW'((int'(last_grant_q) + k) % N_REQ);
            if (!grant_any && req_valid[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
                grant_any       = 1'b1;
            end
        end
    end

    // Pipeline advance conditions
    always_comb begin
        s2_load   = !rsp_valid_q || rsp_ready;
        s1_load   = !s1_valid_q || s2_load;
        req_ready = (ready_en_q && s1_load) ? grant : '0;
        accept    = |req_ready;
    end

    // Sigmoid approximation: 0.5 + x/8 with hard saturation beyond +/-5.0
    always_comb begin
        lin = ($signed({s1_x_q[SFP_W-1], s1_x_q}) >>> 3) + $signed({1'b0, SFP_HALF});
        if (s1_x_q >= SFP_FIVE) begin
            sig_y = SFP_ONE;
        end else if (s1_x_q <= SFP_NFIVE) begin
            sig_y = '0;
        end else if (lin < 0) begin
            sig_y = '0;
        end else if (lin > $signed({1'b0, SFP_ONE})) begin
            sig_y = SFP_ONE;
        end else begin
            sig_y = lin[SFP_W-1:0];
        end
    end

    // Next-state logic for both stages and the arbitration pointer
    always_comb begin
        last_grant_d = last_grant_q;
        s1_valid_d   = s1_valid_q;
        s1_x_d       = s1_x_q;
        s1_id_d      = s1_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        ready_en_d   = 1'b1;

        if (s1_load) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_x_d  = req_data[grant_idx];
                s1_id_d = grant_idx;
            end
        end

        // Pointer only moves on a completed transfer, never on a stalled grant
        if (accept) begin
            last_grant_d = grant_idx;
        end

        if (s2_load) begin
            rsp_valid_d = s1_valid_q;
            rsp_data_d  = sig_y;
            rsp_id_d    = s1_id_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IDW'(N_REQ - 1);
            s1_valid_q   <= 1'b0;
            s1_x_q       <= '0;
            s1_id_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            ready_en_q   <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            s1_valid_q   <= s1_valid_d;
            s1_x_q       <= s1_x_d;
            s1_id_q      <= s1_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            ready_en_q   <= ready_en_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = s1_valid_q || rsp_valid_q;

endmodule
`default_nettype wire
